// File: rtl/sram_mem_pkg.sv
// -----------------------------------------------------------------------------
// sram_mem_pkg
// Shared types and constants for the MEM-stage SRAM controller.
//   sram_state_t    : controller FSM states
//   SRAM_DW         : SRAM data-pad width (half-word)
//   DEF_WAIT_CYCLES : default wait states per half-word phase (1..15)
//   DEF_BASE_ADDR   : default CPU byte address mapped to SRAM word 0
//   DEF_SRAM_AW     : default SRAM half-word address width
// -----------------------------------------------------------------------------
package sram_mem_pkg;

  localparam int SRAM_DW         = 16;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_SRAM_AW     = 18;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } sram_state_t;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl_if
// Bundles the pipeline-side request/response signals and the SRAM pad signals
// of sram_mem_ctrl.
//   pipeline side : rdEn, wrEn, addr, wrData -> ; <- rdData, ready
//   SRAM side     : <- sramDqIn ; -> sramAddr, sramDqOut, sramDqOe, sramWeN
//   debug         : dbg_state (current FSM state)
//   addrErr       : present only when SRAM_ADDR_CHECK_EN is defined
// Modports: slave = controller view, master = pipeline/SRAM environment view.
//
// Handshake: a request (rdEn or wrEn, with addr/wrData) is presented while the
// controller is in IDLE and must stay stable for as long as ready=0. ready=1
// in DONE marks completion; the pipeline advances on that clock edge.
// -----------------------------------------------------------------------------
interface sram_mem_ctrl_if #(
  parameter int SRAM_AW = sram_mem_pkg::DEF_SRAM_AW
);
  import sram_mem_pkg::*;

  logic                 rdEn;
  logic                 wrEn;
  logic [31:0]          addr;
  logic [31:0]          wrData;
  logic [31:0]          rdData;
  logic                 ready;
  logic [SRAM_AW-1:0]   sramAddr;
  logic [SRAM_DW-1:0]   sramDqOut;
  logic [SRAM_DW-1:0]   sramDqIn;
  logic                 sramDqOe;
  logic                 sramWeN;
  sram_state_t          dbg_state;
`ifdef SRAM_ADDR_CHECK_EN
  logic                 addrErr;
`endif

  modport slave (
    input  rdEn, wrEn, addr, wrData, sramDqIn,
`ifdef SRAM_ADDR_CHECK_EN
    output addrErr,
`endif
    output rdData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN, dbg_state
  );

  modport master (
    output rdEn, wrEn, addr, wrData, sramDqIn,
`ifdef SRAM_ADDR_CHECK_EN
    input  addrErr,
`endif
    input  rdData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN, dbg_state
  );

endinterface

// File: rtl/sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl
// MEM-stage data-memory controller. Turns a one-cycle 32-bit load/store from
// the EXE/MEM register into two 16-bit SRAM phases (low half, then high half),
// each held for WAIT_CYCLES cycles. ready freezes the pipeline meanwhile.
// Ports:
//   clk  : pipeline clock
//   rst  : synchronous active-high reset
//   bus  : sram_mem_ctrl_if.slave (pipeline request/response + SRAM pads)
// Parameters: WAIT_CYCLES (1..15), BASE_ADDR, SRAM_AW.
// Optional: SRAM_ADDR_CHECK_EN adds bus.addrErr and rejects out-of-window
// addresses (IDLE -> DONE with no SRAM activity); otherwise addresses wrap.
// -----------------------------------------------------------------------------
module sram_mem_ctrl
  import sram_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic            clk,
  input  logic            rst,
  sram_mem_ctrl_if.slave  bus
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  sram_state_t          r_state;
  sram_state_t          w_next;
  logic [3:0]           r_cnt;
  logic [31:0]          r_rd_data;
  logic [SRAM_DW-1:0]   r_lo_buf;

  logic                 w_req;
  logic                 w_last;
  logic                 w_phase;
  logic [31:0]          w_offset;
  logic [SRAM_AW-2:0]   w_word;
  logic                 w_ready;
  logic                 w_we_n;
  logic                 w_oe;
  logic [SRAM_DW-1:0]   w_dq_out;
  logic [SRAM_AW-1:0]   w_sram_addr;

  assign w_req    = bus.rdEn | bus.wrEn;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_phase  = (r_state == RD_LO) || (r_state == RD_HI) ||
                    (r_state == WR_LO) || (r_state == WR_HI);

  // Byte offset into the SRAM window; the shift drops addr[1:0] and the cast
  // truncates to the word-address width (wrapping out-of-window addresses).
  assign w_offset = bus.addr - 32'(BASE_ADDR);
  assign w_word   = (SRAM_AW-1)'(w_offset >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  localparam logic [32:0] ADDR_END = 33'(BASE_ADDR) + (33'd1 << (SRAM_AW + 1));

  logic w_addr_bad;
  logic r_err;

  assign w_addr_bad = ({1'b0, bus.addr} < 33'(BASE_ADDR)) ||
                      ({1'b0, bus.addr} >= ADDR_END);
  assign bus.addrErr = r_err && (r_state == DONE);
`endif

  // Next-state and SRAM pad outputs
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b1;
    w_we_n      = 1'b1;
    w_oe        = 1'b0;
    w_dq_out    = '0;
    w_sram_addr = '0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_ready = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
          if (w_addr_bad)      w_next = DONE;
          else if (bus.wrEn)   w_next = WR_LO;
          else                 w_next = RD_LO;
`else
          // Write wins when both enables are set.
          if (bus.wrEn) w_next = WR_LO;
          else          w_next = RD_LO;
`endif
        end
      end
      RD_LO: begin
        w_ready     = 1'b0;
        w_sram_addr = {w_word, 1'b0};
        if (w_last) w_next = RD_HI;
      end
      RD_HI: begin
        w_ready     = 1'b0;
        w_sram_addr = {w_word, 1'b1};
        if (w_last) w_next = DONE;
      end
      WR_LO: begin
        w_ready     = 1'b0;
        w_we_n      = 1'b0;
        w_oe        = 1'b1;
        w_dq_out    = bus.wrData[15:0];
        w_sram_addr = {w_word, 1'b0};
        if (w_last) w_next = WR_HI;
      end
      WR_HI: begin
        w_ready     = 1'b0;
        w_we_n      = 1'b0;
        w_oe        = 1'b1;
        w_dq_out    = bus.wrData[31:16];
        w_sram_addr = {w_word, 1'b1};
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_lo_buf  <= '0;
    end else begin
      r_state <= w_next;
      if (w_phase && !w_last) r_cnt <= r_cnt + 4'd1;
      else                    r_cnt <= '0;
      // Low half is staged so rdData changes only when a read completes.
      if (r_state == RD_LO && w_last) r_lo_buf  <= bus.sramDqIn;
      if (r_state == RD_HI && w_last) r_rd_data <= {bus.sramDqIn, r_lo_buf};
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= (r_state == IDLE) && w_req && w_addr_bad;
  end
`endif

  assign bus.rdData    = r_rd_data;
  assign bus.ready     = w_ready;
  assign bus.sramAddr  = w_sram_addr;
  assign bus.sramDqOut = w_dq_out;
  assign bus.sramDqOe  = w_oe;
  assign bus.sramWeN   = w_we_n;
  assign bus.dbg_state = r_state;

endmodule
